// File: rtl/ring_uart_pkg.sv
// Shared constants for the ring-buffer UART drain stage: FSM encoding, default baud divisor, frame length helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ring_uart_pkg;

    // FSM state encoding
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // 100 MHz clock at 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    // Clock cycles occupied by one complete frame, start bit through last stop bit
    function automatic int frame_cycles(input int width, input int clks_per_bit,
                                        input int stop_bits, input int parity_bits);
        return (1 + width + parity_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: bit_end is combinational from the count; clear takes effect on the next edge.
// Backpressure: none; clear holds the count at zero.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] count;

    assign bit_end = (count == CW'(CLKS_PER_BIT - 1));

    // Count within a bit period, restarting at zero after the terminal count or on clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ring_uart_tx.sv
// Drains the ring buffer one word at a time and sends each as a UART frame (start, LSB-first data, stop).
// Latency: start bit appears 1 cycle after the dequeue edge; back-to-back frames have no idle gap.
// Backpressure: pops only when enable_i=1 and empty_i=0 at a frame boundary; optional parity via RING_UART_TX_PARITY_EN.
module ring_uart_tx
    import ring_uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable_i,
    input  logic             empty_i,
    output logic             dequeue_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int IW = $clog2(WIDTH + 1);

    logic [2:0]       state_q, state_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [IW-1:0]    idx_q, idx_nxt;
    logic             tx_q, tx_nxt;
    logic             bit_end;
    logic             last_stop;
    logic             start_ok;
    logic             baud_clear;
`ifdef RING_UART_TX_PARITY_EN
    logic             par_q;
`endif

    // Final cycle of the final stop bit; the only point besides IDLE where a new word may be popped
    assign last_stop  = (state_q == STOP) && bit_end && (idx_q == IW'(STOP_BITS - 1));
    // Gated by rstn so the buffer is never popped while this block is held in reset
    assign start_ok   = rstn & enable_i & ~empty_i & ((state_q == IDLE) | last_stop);
    assign baud_clear = start_ok | (state_q == IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    // State, shift register, bit index and the registered serial line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
`ifdef RING_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            shift_q <= shift_nxt;
            idx_q   <= idx_nxt;
            tx_q    <= tx_nxt;
`ifdef RING_UART_TX_PARITY_EN
            // Parity is taken from the whole word at pop time, before any shifting
            if (start_ok) begin
                par_q <= ^data_i;
            end
`endif
        end
    end

    // Next-state logic; the line level is derived from the next state so tx_o can be a plain flop
    always_comb begin
        state_nxt = state_q;
        shift_nxt = shift_q;
        idx_nxt   = idx_q;
        tx_nxt    = 1'b1;

        case (state_q)
            IDLE: begin
                state_nxt = IDLE;
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_q >> 1;
                    if (idx_q == IW'(WIDTH - 1)) begin
                        idx_nxt = '0;
`ifdef RING_UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
`ifdef RING_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    idx_nxt   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase

        // A pop always lands in START, both from IDLE and straight out of the last stop cycle
        if (start_ok) begin
            state_nxt = START;
            shift_nxt = data_i;
            idx_nxt   = '0;
        end

        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
`ifdef RING_UART_TX_PARITY_EN
            PARITY:  tx_nxt = par_q;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    // Outputs decoded from current state
    always_comb begin
        dequeue_o    = start_ok;
        busy_o       = (state_q != IDLE);
        frame_done_o = last_stop;
        tx_o         = tx_q;
    end

endmodule
